freq_frame_sched: RTL

//  Frame scheduler/arbiter for the spectral effect chain. Owns the single read port of the FFT

---
 rtl/freq_sched_pkg.sv | 28 ++
 rtl/sched_prio_pick.sv | 22 ++
 rtl/freq_frame_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/freq_sched_pkg.sv
//------------------------------------------------------------------------------
// Module  : freq_sched_pkg
// Brief   : Shared defaults, counter widths and state encoding for the frame
//           scheduler of the spectral effect chain.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package freq_sched_pkg;

  localparam int FS_FRAME_LEN    = 1024;
  localparam int FS_NREQ         = 4;
  localparam int FS_GAP_MIN      = 6;
  localparam int FS_DRAIN_MAX    = 15;
  localparam int FS_FRAME_CNT_W  = 16;
  localparam int FS_DROP_CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_WINDOW = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_GAP    = 3'd4
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/sched_prio_pick.sv
//------------------------------------------------------------------------------
// Module  : sched_prio_pick
// Brief   : Combinational fixed-priority picker, lowest set index wins (one-hot).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sched_prio_pick
  import freq_sched_pkg::*;
#(
  parameter int NREQ = FS_NREQ
) (
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] pick
);

  // Two's-complement trick isolates the lowest set bit.
  assign pick = req & (~req + NREQ'(1));

endmodule

`default_nettype wire

// File: rtl/freq_frame_sched.sv
//------------------------------------------------------------------------------
// Module  : freq_frame_sched
// Brief   : Per-frame arbiter for the spectrum RAM read port: ARM, read window,
//           drain for tlast, idle gap. FRAME_SCHED_STATS_EN enables the counters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module freq_frame_sched
  import freq_sched_pkg::*;
#(
  parameter int FRAME_LEN = FS_FRAME_LEN,
  parameter int NREQ      = FS_NREQ,
  parameter int GAP_MIN   = FS_GAP_MIN,
  parameter int DRAIN_MAX = FS_DRAIN_MAX
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_ready,
  input  logic [NREQ-1:0]           mode_req,
  input  logic [NREQ-1:0]           eff_tlast,
  output logic [NREQ-1:0]           grant,
  output logic                      grant_switch,
  output logic                      win_en,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err_timeout,
  output logic                      overrun,
  output logic [FS_FRAME_CNT_W-1:0] frame_cnt,
  output logic [FS_DROP_CNT_W-1:0]  drop_cnt
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] c_win_last   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(DRAIN_MAX - 1);
  localparam logic [CNT_W-1:0] c_gap_last   = CNT_W'(GAP_MIN - 1);

  sched_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  w_pick;
  logic             r_grant_switch;
  logic             r_pending;
  logic             r_err_timeout;
  logic             r_overrun;
  logic             w_start;
  logic             w_tlast_hit;
  logic             w_drain_to;
  logic             w_drain_exit;

  sched_prio_pick #(.NREQ(NREQ)) u_pick (
    .req  (mode_req),
    .pick (w_pick)
  );

  assign w_start      = (r_state == ST_IDLE) && (frame_ready || r_pending) && (|mode_req);
  assign w_tlast_hit  = |(eff_tlast & r_grant);
  assign w_drain_to   = (r_cnt == c_drain_last);
  assign w_drain_exit = (r_state == ST_DRAIN) && (w_tlast_hit || w_drain_to);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_start) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        w_state_nxt = ST_WINDOW;
        w_cnt_nxt   = '0;
      end
      ST_WINDOW: begin
        if (r_cnt == c_win_last) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (w_tlast_hit || w_drain_to) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == c_gap_last) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_grant        <= '0;
      r_grant_switch <= 1'b0;
      r_pending      <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_grant_switch <= 1'b0;
      if (w_start) begin
        r_grant        <= w_pick;
        r_grant_switch <= (w_pick != r_grant);
      end else if ((r_state == ST_IDLE) && !(|mode_req) && (|r_grant)) begin
        // All effects off while idle: fall back to bypass.
        r_grant        <= '0;
        r_grant_switch <= 1'b1;
      end
      if (w_drain_exit && !w_tlast_hit) r_err_timeout <= 1'b1;
      if (r_state == ST_IDLE) begin
        if (w_start) r_pending <= 1'b0;
      end else if (frame_ready) begin
        r_pending <= 1'b1;
        if (r_pending) r_overrun <= 1'b1;
      end
    end
  end

  assign grant        = r_grant;
  assign grant_switch = r_grant_switch;
  assign win_en       = (r_state == ST_WINDOW);
  assign busy         = (r_state != ST_IDLE);
  assign frame_done   = w_drain_exit;
  assign err_timeout  = r_err_timeout;
  assign overrun      = r_overrun;

`ifdef FRAME_SCHED_STATS_EN
  logic [FS_FRAME_CNT_W-1:0] r_frame_cnt;
  logic [FS_DROP_CNT_W-1:0]  r_drop_cnt;
  logic                      w_drop;

  assign w_drop = frame_ready && (r_state != ST_IDLE) && r_pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_drain_exit) r_frame_cnt <= r_frame_cnt + FS_FRAME_CNT_W'(1);
      if (w_drop && (r_drop_cnt != {FS_DROP_CNT_W{1'b1}}))
        r_drop_cnt <= r_drop_cnt + FS_DROP_CNT_W'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

`default_nettype wire
